sum_decode_serial: RTL and testbench

SUM_DECODE_SERIAL -- requirements
Module: sum_decode_serial

---
 rtl/sum_decode_pkg.sv | 16 +
 rtl/fsub_cell.sv | 14 +
 rtl/sum_decode_serial.sv | 129 ++++++++++++
 tb/tb_sum_decode_serial.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_decode_pkg.sv
// Shared types for the serial sum decoder: FSM state encoding and counter sizing.
// No logic of its own; imported by the decoder top.
package sum_decode_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Bit counter must reach WIDTH without wrapping, hence WIDTH+1 distinct values.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fsub_cell.sv
// 1-bit full subtractor: d = s - a - bin, bout set when the bit underflows.
// Purely combinational, no latency, no flow control.
module fsub_cell (
    input  logic s,
    input  logic a,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = s ^ a ^ bin;
    assign bout = (~s & a) | (~(s ^ a) & bin);

endmodule

// File: rtl/sum_decode_serial.sv
// Serial sum decoder: recovers opb = sum - opa one bit per cycle, LSB first; result valid WIDTH+1 cycles after accept.
// in_ready only while idle; the result is held stable until out_ready, so one job per WIDTH+2 cycles at best.
module sum_decode_serial
    import sum_decode_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum_i,
    input  logic [WIDTH-1:0] opa_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] opb_o,
    output logic             err_o
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             err_q, err_d;
    logic             bor_q, bor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_rdy_q, in_rdy_d;
    logic             out_vld_q, out_vld_d;

    logic             s_bit;
    logic             a_bit;
    logic             d_bit;
    logic             bout;

    // Mux the current bit out of the captured operands; the operands themselves never shift.
    always_comb begin
        s_bit = 1'b0;
        a_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) begin
                s_bit = sum_q[i];
                a_bit = opa_q[i];
            end
        end
    end

    fsub_cell u_fsub (
        .s    (s_bit),
        .a    (a_bit),
        .bin  (bor_q),
        .d    (d_bit),
        .bout (bout)
    );

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        err_d   = err_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sum_d   = sum_i;
                    opa_d   = opa_i;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opb_d = {d_bit, opb_q[WIDTH-1:1]};
                bor_d = bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Carry-out and final borrow disagree exactly when sum - opa leaves 0..2^WIDTH-1.
                    err_d   = sum_q[WIDTH] ^ bout;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_rdy_d  = (state_d == IDLE);
        out_vld_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sum_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            err_q     <= 1'b0;
            bor_q     <= 1'b0;
            cnt_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            err_q     <= err_d;
            bor_q     <= bor_d;
            cnt_q     <= cnt_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld_q;
    assign opb_o     = opb_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_sum_decode_serial.sv
// Bench for sum_decode_serial at WIDTH=8: directed vectors, backpressure, reset abort, streaming and random jobs.
module tb_sum_decode_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   sum_i;
    logic [W-1:0] opa_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] opb_o;
    logic         err_o;

    int errors = 0;
    int checks = 0;

    sum_decode_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_i     (sum_i),
        .opa_i     (opa_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opb_o     (opb_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    // Reference: plain integer subtraction; error whenever the difference is out of the W-bit range.
    function automatic void model(input int s, input int a, output logic [W-1:0] opb, output logic e);
        int diff;
        diff = s - a;
        opb  = diff[W-1:0];
        e    = (diff < 0) || (diff > (1 << W) - 1);
    endfunction

    // Presents one job, then returns edges from accept to out_valid (40 means it never came).
    task automatic drive_job(input logic [W:0] s, input logic [W-1:0] a,
                             output int lat, output logic [W-1:0] opb, output logic e);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        sum_i    = s;
        opa_i    = a;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sum_i    = (W+1)'($urandom);
        opa_i    = W'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        opb = opb_o;
        e   = err_o;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_i     = '0;
        opa_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, opb_o, err_o} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b opb=%h err=%b, want rdy=1 vld=0 opb=00 err=0",
                     in_ready, out_valid, opb_o, err_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W:0]   s_tab [3];
        logic [W-1:0] a_tab [3];
        logic [W-1:0] opb_exp [3];
        logic         err_exp [3];
        int           lat;
        logic [W-1:0] opb;
        logic         e;
        s_tab = '{9'h0FF, 9'h1FE, 9'h005};
        a_tab = '{8'h0F, 8'hFF, 8'h06};
        opb_exp = '{8'hF0, 8'hFF, 8'hFF};
        err_exp = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            drive_job(s_tab[k], a_tab[k], lat, opb, e);
            checks++;
            if (lat !== W) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", k, lat, W);
            end
            checks++;
            if ({opb, e} !== {opb_exp[k], err_exp[k]}) begin
                errors++;
                $display("FAIL directed_result[%0d]: got opb=%h err=%b, want opb=%h err=%b",
                         k, opb, e, opb_exp[k], err_exp[k]);
            end
            release_out();
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                errors++;
                $display("FAIL directed_release[%0d]: got rdy=%b vld=%b, want rdy=1 vld=0", k, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_hold();
        int           lat;
        logic [W-1:0] opb;
        logic         e;
        logic [W-1:0] opb_exp;
        logic         err_exp;
        model(9'h0A3, 8'h21, opb_exp, err_exp);
        drive_job(9'h0A3, 8'h21, lat, opb, e);
        checks++;
        if ({opb, e} !== {opb_exp, err_exp}) begin
            errors++;
            $display("FAIL hold_result: got opb=%h err=%b, want opb=%h err=%b", opb, e, opb_exp, err_exp);
        end
        for (int k = 0; k < 5; k++) begin
            sum_i    = (W+1)'($urandom);
            opa_i    = W'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, opb_o, err_o} !== {1'b1, 1'b0, opb_exp, err_exp}) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b opb=%h err=%b, want vld=1 rdy=0 opb=%h err=%b",
                         k, out_valid, in_ready, opb_o, err_o, opb_exp, err_exp);
            end
        end
        in_valid = 1'b0;
        release_out();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL hold_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_abort();
        int           lat;
        logic [W-1:0] opb_exp;
        logic         err_exp;
        in_valid = 1'b1;
        sum_i    = 9'h1C4;
        opa_i    = 8'h3B;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, opb_o, err_o} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL abort_reset: got rdy=%b vld=%b opb=%h err=%b, want rdy=1 vld=0 opb=00 err=0",
                     in_ready, out_valid, opb_o, err_o);
        end
        // New job presented on the very first edge out of reset.
        model(9'h077, 8'h80, opb_exp, err_exp);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        sum_i    = 9'h077;
        opa_i    = 8'h80;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_first_accept: got rdy=%b, want rdy=0", in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL abort_latency: got %0d edges, want %0d", lat, W);
        end
        checks++;
        if ({opb_o, err_o} !== {opb_exp, err_exp}) begin
            errors++;
            $display("FAIL abort_result: got opb=%h err=%b, want opb=%h err=%b", opb_o, err_o, opb_exp, err_exp);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [W:0]   q_s [$];
        logic [W-1:0] q_a [$];
        logic [W-1:0] opb_exp;
        logic         err_exp;
        logic [W:0]   s;
        logic [W-1:0] a;
        int           last_acc;
        int           results;
        int           cyc;
        last_acc  = -1;
        results   = 0;
        cyc       = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (results < 6 && cyc < 200) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (q_s.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: result opb=%h with no job outstanding", opb_o);
                end else begin
                    s = q_s.pop_front();
                    a = q_a.pop_front();
                    model(int'(s), int'(a), opb_exp, err_exp);
                    if ({opb_o, err_o} !== {opb_exp, err_exp}) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got opb=%h err=%b, want opb=%h err=%b",
                                 results, opb_o, err_o, opb_exp, err_exp);
                    end
                end
                results++;
            end
            s = (W+1)'($urandom);
            a = W'($urandom);
            sum_i = s;
            opa_i = a;
            if (in_ready === 1'b1 && results < 6) begin
                q_s.push_back(s);
                q_a.push_back(a);
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== W + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles between accepts, want %0d", cyc - last_acc, W + 2);
                    end
                end
                last_acc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (results !== 6) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d results in %0d cycles, want 6", results, cyc);
        end
        repeat (W + 3) @(posedge clk);
        #1;
        if (out_valid === 1'b1) release_out();
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   s;
        int           lat;
        logic [W-1:0] opb;
        logic         e;
        int           hold;
        for (int n = 0; n < 1000; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = {1'b0, a} + {1'b0, b};
            drive_job(s, a, lat, opb, e);
            checks++;
            if (lat !== W || opb !== b || e !== 1'b0) begin
                errors++;
                $display("FAIL random[%0d]: opa=%h sum=%h got lat=%0d opb=%h err=%b, want lat=%0d opb=%h err=0",
                         n, a, s, lat, opb, e, W, b);
            end
            hold = $urandom_range(0, 2);
            repeat (hold) @(posedge clk);
            #1;
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
